// File: rtl/three_bit_dff_up_counter_w_asyn_clock.sv
// Ripple binary up-counter: a chain of toggle flip-flops, each stage
// after the first clocked by the inverted output of the stage before it.

module toggle_dff (
    input  logic clk,
    input  logic clr,
    input  logic en,
    output logic q
);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q <= 1'b0;
        end else if (en) begin
            q <= ~q;
        end
    end

endmodule

module three_bit_dff_up_counter_w_asyn_clock #(
    parameter int WIDTH = 3
) (
    output logic [WIDTH-1:0] count,
    input  logic             Clk,
    input  logic             Clr
);

    logic [WIDTH-1:0] stage_clk;
    logic [WIDTH-1:0] stage_en;
    logic             clr_n;
    logic             armed;

    assign clr_n = ~Clr;

    // Set on the falling edge of Clr, so a Clk edge in the same instant
    // still sees armed = 0 and is ignored.
    always_ff @(posedge clr_n or posedge Clr) begin
        if (Clr) begin
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
        end
    end

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_stage
            if (i == 0) begin : g_first
                assign stage_clk[i] = Clk;
                assign stage_en[i]  = armed;
            end else begin : g_ripple
                assign stage_clk[i] = ~count[i-1];
                assign stage_en[i]  = 1'b1;
            end

            toggle_dff u_dff (
                .clk (stage_clk[i]),
                .clr (Clr),
                .en  (stage_en[i]),
                .q   (count[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_three_bit_dff_up_counter_w_asyn_clock.sv
// Directed-vector bench for the 3-bit ripple up-counter.
// Clock rises at 20 ns and every 40 ns after.

module tb_three_bit_dff_up_counter_w_asyn_clock;

    logic       Clk;
    logic       Clr;
    logic [2:0] count;

    int n_tests;
    int n_fail;

    three_bit_dff_up_counter_w_asyn_clock #(.WIDTH(3)) dut (
        .count (count),
        .Clk   (Clk),
        .Clr   (Clr)
    );

    initial Clk = 1'b0;
    always #20 Clk = ~Clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t",
                     tag, got, exp, $time);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seq_exp [9];
        logic [2:0] prev;
        logic [2:0] cur;
        seq_exp = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
        n_tests = 0;
        n_fail  = 0;

        // power-up in clear
        Clr = 1'b1;
        #1;
        check("powerup", int'(count), 0);
        @(posedge Clk);
        #1;
        check("clr_edge20", int'(count), 0);

        // release at 45 ns, count from 60 ns through the wrap
        #24;
        Clr = 1'b0;
        for (int k = 0; k < 9; k++) begin
            @(posedge Clk);
            #1;
            check($sformatf("seq%0d", k), int'(count), seq_exp[k]);
        end

        // advance to 5 (edge at 540 ns)
        repeat (4) @(posedge Clk);
        #1;
        check("pre_clr5", int'(count), 5);

        // async clear between edges, held through two edges
        #9;
        Clr = 1'b1;
        #1;
        check("clr_async", int'(count), 0);
        for (int k = 0; k < 2; k++) begin
            @(posedge Clk);
            #1;
            check($sformatf("clr_hold%0d", k), int'(count), 0);
        end
        #9;
        Clr = 1'b0;
        @(posedge Clk);
        #1;
        check("post_release", int'(count), 1);

        // release coincident with a rising edge
        #5;
        Clr = 1'b1;
        #1;
        check("clr_again", int'(count), 0);
        @(posedge Clk);
        Clr = 1'b0;
        #1;
        check("coincident_edge", int'(count), 0);
        @(posedge Clk);
        #1;
        check("after_coincident", int'(count), 1);

        // 1000 ns of ripple-relation checks at settled edges
        prev = count;
        for (int k = 0; k < 25; k++) begin
            @(posedge Clk);
            #1;
            cur = count;
            check($sformatf("rip%0d_b0", k),
                  int'(cur[0] ^ prev[0]), 1);
            for (int b = 1; b < 3; b++) begin
                check($sformatf("rip%0d_b%0d", k, b),
                      int'(cur[b] ^ prev[b]),
                      int'(prev[b-1] & ~cur[b-1]));
            end
            check($sformatf("rip%0d_val", k),
                  int'(cur), (int'(prev) + 1) % 8);
            prev = cur;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
